tile_writer: RTL and testbench
==============================

TILE_WRITER -- requirements
Module: tile_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of one buffer word.
REQ-002 Parameter ADDR_WIDTH, default 8, buffer address width.
REQ-003 i_clk  input  1  clock; all state updates on the rising edge.
REQ-004 i_nrst  input  1  reset, asynchronous, active-low.
REQ-005 i_write_en  input  1  level enable; starts a tile write from IDLE and pauses acceptance in WRITE when low.
REQ-006 i_reg_clear  input  1  synchronous clear; highest priority after reset.
REQ-007 i_start_addr  input  ADDR_WIDTH  base buffer address of the tile.
REQ-008 i_addr_end  input  ADDR_WIDTH  offset of the last word; tile length is i_addr_end+1.
REQ-009 i_data_valid  input  1  upstream word valid.
REQ-010 i_data  input  DATA_WIDTH  upstream word.
REQ-011 o_data_ready  output  1  block accepts a word this cycle.
REQ-012 o_buf_write_en  output  1  buffer write strobe, one cycle per word.
REQ-013 o_write_addr  output  ADDR_WIDTH  buffer write address.
REQ-014 o_write_data  output  DATA_WIDTH  buffer write data.
REQ-015 o_write_done  output  1  whole tile written; held until cleared.
REQ-016 o_word_count  output  ADDR_WIDTH+1  words accepted so far in the current tile.

Function
REQ-017 FSM states: IDLE, WRITE, DONE.
REQ-018 IDLE -> WRITE when i_write_en=1: latch i_start_addr and i_addr_end into internal registers and set the counter to 0.
REQ-019 Later changes on i_start_addr and i_addr_end do not affect the tile in progress.
REQ-020 o_data_ready = (state==WRITE) & i_write_en, combinational from registered state only, with no path from i_data_valid.
REQ-021 Handshake: a word is accepted only in a cycle where i_data_valid & o_data_ready is high.
REQ-022 Upstream holds i_data stable while valid and not ready.
REQ-023 On acceptance, in the next cycle: o_buf_write_en=1, o_write_addr=latched start + counter (modulo 2^ADDR_WIDTH, wraps silently), o_write_data=i_data captured at acceptance.
REQ-024 Latency from acceptance to write strobe is exactly 1 cycle.
REQ-025 On acceptance, counter increments.
REQ-026 o_buf_write_en=0 in any cycle following no acceptance.
REQ-027 o_write_addr and o_write_data hold their last values while the strobe is low.
REQ-028 The accepted word with counter == latched end is the last beat: WRITE -> DONE on that edge.
REQ-029 o_write_done=1 is registered, asserted in the same cycle as the final o_buf_write_en.
REQ-030 In DONE: o_data_ready=0, o_write_done held at 1, i_write_en ignored; exit only via i_reg_clear or reset.
REQ-031 i_write_en low in WRITE: no acceptance; counter, latched addresses and o_word_count are held; resumes when i_write_en returns high.
REQ-032 i_addr_end=0: tile is exactly one word.
REQ-033 i_addr_end = 2^ADDR_WIDTH-1: 2^ADDR_WIDTH words, with no counter overflow (counter is ADDR_WIDTH+1 bits).
REQ-034 o_word_count = counter; it reaches i_addr_end+1 at DONE.
REQ-035 i_reg_clear=1 in any state, including mid-tile or with acceptance pending: next state IDLE, counter 0, o_buf_write_en 0, o_write_done 0, o_write_addr 0, o_write_data 0.
REQ-036 A word presented together with i_reg_clear is not accepted, because clear masks o_data_ready.
REQ-037 i_reg_clear and i_write_en high together in IDLE: clear wins and the block stays IDLE that cycle.

Reset
REQ-038 i_nrst low asynchronously forces: state IDLE, counter 0, latched start/end 0, o_buf_write_en 0, o_write_addr 0, o_write_data 0, o_write_done 0, o_word_count 0.
REQ-039 While i_nrst is low, o_data_ready=0.
REQ-040 Reset asserted mid-tile discards the tile; no further write strobe is issued after release until a new start.

Verification
REQ-041 start=0x10, end=3, continuous valid -> strobes at 0x10..0x13 on 4 consecutive cycles, each 1 cycle after its handshake, data matching; o_write_done rises with the 0x13 strobe; o_word_count=4.
REQ-042 start=0xFE, end=3 -> writes to 0xFE, 0xFF, 0x00, 0x01 (wrap), done after the 4th.
REQ-043 Valid toggled 1-0-1-1-0-1 with end=3, plus i_write_en low for 2 cycles mid-tile -> exactly 4 strobes, in order, with no strobe during pause or gap cycles; o_word_count frozen during the pause.
REQ-044 end=0 -> single strobe at start; DONE; further valid words are not accepted (ready=0).
REQ-045 i_reg_clear pulsed after 2 of 5 words -> IDLE, outputs 0, o_write_done 0; re-start writes the full 5 words from offset 0.
REQ-046 i_nrst asserted mid-tile between clock edges -> all outputs 0 immediately; after release the block stays IDLE until i_write_en.

Source files
------------

// File: rtl/tile_writer.sv
// tile_writer: accepts a tile of upstream words and writes them to consecutive buffer
// addresses starting at a latched base, flagging completion until cleared.
module tile_writer #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_write_en,
    input  logic                  i_reg_clear,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    input  logic [ADDR_WIDTH-1:0] i_addr_end,
    input  logic                  i_data_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_data_ready,
    output logic                  o_buf_write_en,
    output logic [ADDR_WIDTH-1:0] o_write_addr,
    output logic [DATA_WIDTH-1:0] o_write_data,
    output logic                  o_write_done,
    output logic [ADDR_WIDTH:0]   o_word_count
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
    state_t state, state_nxt;
    logic [ADDR_WIDTH-1:0] start_q, end_q;
    logic [ADDR_WIDTH:0] cnt;
    logic accept, last, start;
    // Clear masks ready so a word offered alongside it is never taken
    assign o_data_ready = (state == WRITE) & i_write_en & ~i_reg_clear;
    assign accept = i_data_valid & o_data_ready;
    assign last = cnt == {1'b0, end_q};
    assign start = (state == IDLE) & i_write_en;
    assign o_word_count = cnt;
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        if (i_reg_clear) state_nxt = IDLE;
        else if (start) state_nxt = WRITE;
        else if (accept && last) state_nxt = DONE;
    end
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst || i_reg_clear) begin
            start_q        <= '0;
            end_q          <= '0;
            cnt            <= '0;
            o_buf_write_en <= 1'b0;
            o_write_addr   <= '0;
            o_write_data   <= '0;
            o_write_done   <= 1'b0;
        end else begin
            o_buf_write_en <= accept;
            if (start) begin
                start_q <= i_start_addr;
                end_q   <= i_addr_end;
                cnt     <= '0;
            end
            // Address wraps modulo the buffer size; the counter has a spare bit for a full-buffer tile
            if (accept) begin
                o_write_addr <= start_q + cnt[ADDR_WIDTH-1:0];
                o_write_data <= i_data;
                cnt          <= cnt + 1'b1;
                if (last) o_write_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tile_writer.sv
// tb_tile_writer: directed stimulus with a reference model feeding a scoreboard queue;
// a negedge monitor pops and checks every buffer write strobe.
module tb_tile_writer;
    localparam int DW = 64;
    localparam int AW = 8;

    logic          i_clk = 1'b0;
    logic          i_nrst = 1'b0;
    logic          i_write_en = 1'b0;
    logic          i_reg_clear = 1'b0;
    logic [AW-1:0] i_start_addr = '0;
    logic [AW-1:0] i_addr_end = '0;
    logic          i_data_valid = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          o_data_ready;
    logic          o_buf_write_en;
    logic [AW-1:0] o_write_addr;
    logic [DW-1:0] o_write_data;
    logic          o_write_done;
    logic [AW:0]   o_word_count;

    tile_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_write_en(i_write_en), .i_reg_clear(i_reg_clear),
        .i_start_addr(i_start_addr), .i_addr_end(i_addr_end), .i_data_valid(i_data_valid),
        .i_data(i_data), .o_data_ready(o_data_ready), .o_buf_write_en(o_buf_write_en),
        .o_write_addr(o_write_addr), .o_write_data(o_write_data), .o_write_done(o_write_done),
        .o_word_count(o_word_count)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc++;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          done;
        int            cnt;
        int            cyc;
    } exp_t;
    exp_t q[$];
    exp_t me;

    int n_chk = 0;
    int n_fail = 0;
    int ms = 0;
    int mk = 0;
    logic [AW-1:0] m_base = '0;
    logic [AW-1:0] m_end = '0;
    logic [AW-1:0] l_addr = '0;
    logic [DW-1:0] l_data = '0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
        end
    endtask

    always @(negedge i_clk) begin
        if (i_nrst) begin
            if (o_buf_write_en) begin
                if (q.size() == 0) chk("unexpected_strobe", 64'd1, 64'd0);
                else begin
                    me = q.pop_front();
                    chk("strobe_addr", 64'(o_write_addr), 64'(me.addr));
                    chk("strobe_data", o_write_data, me.data);
                    chk("strobe_done", 64'(o_write_done), 64'(me.done));
                    chk("strobe_count", 64'(o_word_count), 64'(me.cnt));
                    chk("strobe_latency", 64'(cyc), 64'(me.cyc));
                    l_addr = me.addr;
                    l_data = me.data;
                end
            end else begin
                chk("hold_addr", 64'(o_write_addr), 64'(l_addr));
                chk("hold_data", o_write_data, l_data);
                if (q.size() > 0 && q[0].cyc <= cyc) begin
                    chk("missing_strobe", 64'd0, 64'd1);
                    void'(q.pop_front());
                end
            end
        end
    end

    // One cycle of stimulus; the model predicts ready/count/done before the edge and queues writes
    task automatic step(input logic v, input logic we, input logic clr, input logic [DW-1:0] d);
        logic er;
        exp_t e;
        i_data_valid = v;
        i_write_en = we;
        i_reg_clear = clr;
        i_data = d;
        #1;
        er = (ms == 1) && we && !clr;
        chk("ready", 64'(o_data_ready), 64'(er));
        chk("word_count", 64'(o_word_count), 64'(mk));
        chk("done_flag", 64'(o_write_done), 64'(ms == 2));
        if (clr) begin
            ms = 0; mk = 0; l_addr = '0; l_data = '0;
        end else if (ms == 0 && we) begin
            ms = 1; mk = 0; m_base = i_start_addr; m_end = i_addr_end;
        end else if (v && er) begin
            e.addr = m_base + AW'(mk);
            e.data = d;
            e.done = (mk == int'(m_end));
            e.cnt = mk + 1;
            e.cyc = cyc + 1;
            q.push_back(e);
            if (mk == int'(m_end)) ms = 2;
            mk++;
        end
        @(negedge i_clk);
    endtask

    task automatic check_zero(input string n);
        chk({n, "_we"}, 64'(o_buf_write_en), 64'd0);
        chk({n, "_addr"}, 64'(o_write_addr), 64'd0);
        chk({n, "_data"}, o_write_data, 64'd0);
        chk({n, "_done"}, 64'(o_write_done), 64'd0);
        chk({n, "_count"}, 64'(o_word_count), 64'd0);
    endtask

    task automatic begin_tile(input logic [AW-1:0] s, input logic [AW-1:0] e);
        i_start_addr = s;
        i_addr_end = e;
        step(1'b0, 1'b1, 1'b0, '0);
    endtask

    initial begin
        #1;
        check_zero("reset");
        chk("reset_ready", 64'(o_data_ready), 64'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_nrst = 1'b1;
        step(1'b0, 1'b0, 1'b0, '0);

        // Basic tile; base/end inputs change after latching and must be ignored
        begin_tile(8'h10, 8'd3);
        i_start_addr = 8'h77;
        i_addr_end = 8'd0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 64'hA0 + 64'(i));
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, 64'hDEAD);
        step(1'b0, 1'b0, 1'b1, '0);
        check_zero("clear1");

        // Address wrap
        begin_tile(8'hFE, 8'd3);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 64'h1234_0000 + 64'(i));
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, '0);

        // Valid gaps and an enable pause with valid held high
        begin_tile(8'h20, 8'd3);
        step(1'b1, 1'b1, 1'b0, 64'hB0);
        step(1'b0, 1'b1, 1'b0, 64'hFF);
        step(1'b1, 1'b1, 1'b0, 64'hB1);
        step(1'b1, 1'b0, 1'b0, 64'hB2);
        step(1'b1, 1'b0, 1'b0, 64'hB2);
        step(1'b1, 1'b1, 1'b0, 64'hB2);
        step(1'b0, 1'b1, 1'b0, 64'hEE);
        step(1'b1, 1'b1, 1'b0, 64'hB3);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, '0);

        // Single-word tile; DONE refuses further words
        begin_tile(8'h40, 8'd0);
        step(1'b1, 1'b1, 1'b0, 64'hC0);
        step(1'b1, 1'b1, 1'b0, 64'hC1);
        step(1'b1, 1'b1, 1'b0, 64'hC2);
        step(1'b0, 1'b0, 1'b1, '0);

        // Clear beats enable in IDLE, then clear mid-tile with a word pending, then restart
        i_start_addr = 8'h80;
        i_addr_end = 8'd4;
        step(1'b0, 1'b1, 1'b1, '0);
        step(1'b1, 1'b1, 1'b0, 64'h0BAD);
        step(1'b1, 1'b1, 1'b0, 64'hD0);
        step(1'b1, 1'b1, 1'b0, 64'hD1);
        step(1'b1, 1'b1, 1'b1, 64'hD2);
        check_zero("clear_mid");
        begin_tile(8'h80, 8'd4);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 64'hE0 + 64'(i));
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, '0);

        // Full-buffer tile: counter must reach 2^AW without overflowing
        begin_tile(8'h00, 8'hFF);
        for (int i = 0; i < 256; i++) step(1'b1, 1'b1, 1'b0, 64'(i) * 64'd3 + 64'h5);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("full_count", 64'(o_word_count), 64'd256);
        step(1'b0, 1'b0, 1'b1, '0);

        // Asynchronous reset between edges mid-tile
        begin_tile(8'h30, 8'd5);
        step(1'b1, 1'b1, 1'b0, 64'hF0);
        step(1'b1, 1'b1, 1'b0, 64'hF1);
        #2;
        i_nrst = 1'b0;
        #1;
        check_zero("async_reset");
        chk("async_reset_ready", 64'(o_data_ready), 64'd0);
        ms = 0; mk = 0; l_addr = '0; l_data = '0;
        @(negedge i_clk);
        i_nrst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 64'h99);
        begin_tile(8'h30, 8'd5);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 64'h300 + 64'(i));
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);

        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
